// File: rtl/grid_responder.sv
`default_nettype none
// ============================================================================
// Module   : grid_responder
// Purpose  : Level-map store (64 x 32 cells of 3-bit codes) and responder for
//            grid lookups from two read clients:
//            A = player updater, B = raycaster.
//            Every read takes a fixed 3 cycles. Map writes come from the level
//            loader / door logic and are accepted only while ready=1.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            req_a, grid_x_a/y_a     - client A request (level) and cell
//            ack_a, grid_out_a       - client A ack pulse and held cell code
//            req_b, grid_x_b/y_b     - client B request (level) and cell
//            ack_b, grid_out_b       - client B ack pulse and held cell code
//            wr_en, wr_x/wr_y, wr_data - map write strobe, cell and code
//            ready                   - high only while idle
// Revision : 1.0 - initial release
// ============================================================================
module grid_responder #(
  parameter int         MAP_W          = 40,
  parameter int         MAP_H          = 24,
  parameter logic [2:0] OOB_CODE       = 3'b001,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [5:0] grid_x_a,
  input  logic [4:0] grid_y_a,
  output logic       ack_a,
  output logic [2:0] grid_out_a,
  input  logic       req_b,
  input  logic [5:0] grid_x_b,
  input  logic [4:0] grid_y_b,
  output logic       ack_b,
  output logic [2:0] grid_out_b,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_data,
  output logic       ready
);

  // Limits widened by one bit so MAP_W=64 / MAP_H=32 still compare correctly.
  localparam logic [6:0]  X_LIM    = 7'(MAP_W);
  localparam logic [5:0]  Y_LIM    = 6'(MAP_H);
  localparam logic [10:0] LAST_ADR = 11'h7FF;

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_IDLE    = 2'd1,
    S_LOOKUP  = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t      state, state_next;

  logic [2:0]  mem [0:2047];
  logic [2:0]  rd_data;

  logic [10:0] clr_addr;
  logic [10:0] lat_addr;
  logic        lat_oob;
  logic        lat_b;       // winner of the read in flight: 1 = client B
  logic        last_b;      // client served most recently: 1 = client B

  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [2:0]  ram_wdata;
  logic        latch_req;
  logic        win_b;
  logic        wr_in_range;
  logic        a_in_range;
  logic        b_in_range;

  function automatic logic in_range(input logic [5:0] x, input logic [4:0] y);
    return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  endfunction

  assign wr_in_range = in_range(wr_x, wr_y);
  assign a_in_range  = in_range(grid_x_a, grid_y_a);
  assign b_in_range  = in_range(grid_x_b, grid_y_b);

  // B wins when it is alone, or on a tie when A was the last one served.
  assign win_b = req_b & (~req_a | ~last_b);

  assign ready = (state == S_IDLE);

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_waddr  = {wr_y, wr_x};
    ram_wdata  = wr_data;
    latch_req  = 1'b0;
    case (state)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = 3'b000;
        if (clr_addr == LAST_ADR) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        // A write takes the cycle; any pending read waits for a later one.
        if (wr_en) begin
          ram_we = wr_in_range;
        end else if (req_a | req_b) begin
          latch_req  = 1'b1;
          state_next = S_LOOKUP;
        end
      end
      S_LOOKUP:  state_next = S_RESPOND;
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_addr   <= 11'd0;
      lat_addr   <= 11'd0;
      lat_oob    <= 1'b0;
      lat_b      <= 1'b0;
      last_b     <= 1'b1;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      grid_out_a <= 3'b000;
      grid_out_b <= 3'b000;
    end else begin
      state <= state_next;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (state == S_CLEAR) begin
        clr_addr <= clr_addr + 11'd1;
      end
      if (latch_req) begin
        lat_b    <= win_b;
        last_b   <= win_b;
        lat_addr <= win_b ? {grid_y_b, grid_x_b} : {grid_y_a, grid_x_a};
        lat_oob  <= win_b ? ~b_in_range : ~a_in_range;
      end
      if (state == S_RESPOND) begin
        if (lat_b) begin
          ack_b      <= 1'b1;
          grid_out_b <= lat_oob ? OOB_CODE : rd_data;
        end else begin
          ack_a      <= 1'b1;
          grid_out_a <= lat_oob ? OOB_CODE : rd_data;
        end
      end
    end
  end

  // Map RAM: one write port, one registered read port. Writes only happen in
  // CLEAR and IDLE and reads only in LOOKUP, so the ports never collide.
  always_ff @(posedge clock) begin
    if (ram_we && !reset) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (state == S_LOOKUP) begin
      rd_data <= mem[lat_addr];
    end
  end

endmodule
`default_nettype wire
